rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
Parametrised round-robin arbiter, successor to the single-cycle fixed-priority arbiter. Grants are combinational from the current requests, giving same-cycle grant, and the pointer is registered. Adds a fair rotating priority, an ack-qualified pointer advance, and an optional lock that holds a grant across multi-cycle transactions. Sits in front of shared resources such as bus ports or memory banks.

Parameters:
N, 32, number of requesters (N >= 1).
IDX_W, $clog2(N) (min 1), width of pointer/owner index (derived; do not override).

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
req_i  input  N  request vector, bit i = requester i.
ack_i  input  1  downstream accepts current grant this cycle.
lock_i  input  1  with ack_i, the accepted grant is locked to its owner.
gnt_o  output  N  one-hot or all-zero grant, combinational from req_i and state.
busy_o  output  1  high while in LOCKED state.

Behaviour:
- Reset (async assert, sync release): ptr=0, owner=0, state=IDLE; gnt_o forced 0 while reset is high; busy_o=0.
- State IDLE: gnt_o = first set bit of req_i searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1. gnt_o=0 if req_i=0. Zero-cycle latency.
- IDLE, ack_i=1 and gnt_o!=0, granted index g:
  - lock_i=0 -> ptr <= (g+1) mod N; stay IDLE.
  - lock_i=1 -> owner <= g; state <= LOCKED; ptr unchanged.
- IDLE, ack_i=1 and gnt_o=0 -> ignored; no state change.
- IDLE, ack_i=0 -> ptr holds; the grant may change freely with req_i.
- State LOCKED: gnt_o = onehot(owner) if req_i[owner] else 0; other requests are ignored; busy_o=1.
- LOCKED exit, either condition -> ptr <= (owner+1) mod N; state <= IDLE:
  - req_i[owner]=0, checked combinationally at that cycle's end;
  - ack_i=1 and lock_i=0 while the grant is asserted (final beat).
- LOCKED, ack_i=1 and lock_i=1 -> remain LOCKED.
- Exit is registered: the cycle after exit, arbitration restarts from owner+1.
- Wrap: the pointer increment wraps N-1 -> 0. For non-power-of-2 N the pointer never holds a value >= N.
- N=1: gnt_o = req_i gated by ~reset. LOCKED still tracked; the pointer is constant 0.
- gnt_o has at most one bit set in every cycle (invariant).
- Reset mid-LOCKED: returns to IDLE/ptr=0 immediately. gnt_o=0 while reset is high.

Optional Feature:
Macro RR_LOCK_ARB_GNT_IDX_EN.
- Defined: adds output gnt_idx_o (IDX_W) = binary index of the granted bit, and gnt_vld_o (1) = |gnt_o. Both are combinational and 0 during reset.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package rr_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED};
  - function for index width (clog2 with minimum 1);
  - function onehot-to-index.
- Sub-module rr_prio_pick (N): combinational; inputs req, start index; output one-hot grant. Implement as a rotate, fixed-priority pick, then rotate back.
- The top holds the FSM, ptr, owner, and the output gating.

Test Plan:
- N=4, reset released, req=4'b1010, ack=1, lock=0 each cycle:
  - expected grants 0010, 1000, 0010, 1000;
  - ptr sequence 0->2->0->2.
- N=4, req=4'b1111, ack=0 for 3 cycles: gnt stays 0001, ptr stays 0. Then ack=1 for 4 cycles -> grants 0001, 0010, 0100, 1000, then wraps to 0001.
- N=4, ptr=1, req=1111, ack=1, lock=1:
  - next cycle busy=1 and gnt=0010 while req[0], req[2] and req[3] stay high;
  - ack=1 with lock=0 -> busy=0, then gnt=0100.
- LOCKED on owner 3, req[3] drops while req=0001 -> gnt=0 that cycle; next cycle IDLE, gnt=0001 (ptr wrapped to 0).
- Assert reset asynchronously mid-LOCKED (owner 2) -> gnt=0 and busy=0 immediately. After release, req=1100 -> gnt=0100.
- N=5 and N=1 builds:
  - N=5, req=10001, ack=1 -> grants alternate 00001/10000, ptr never exceeds 4;
  - N=1, gnt equals req;
  - with RR_LOCK_ARB_GNT_IDX_EN defined, gnt_idx matches the grant and gnt_vld=|gnt in all the above.

Source files
------------

// File: rtl/rr_lock_arbiter_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin lock arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED).
//   idx_width() : index width for N requesters, clog2 with a minimum of 1.
//   oh_to_idx() : binary index of a one-hot vector (0 for an all-zero vector).
// Used by: rr_lock_arbiter (top) and rr_prio_pick.
package rr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Widest vector oh_to_idx accepts; callers zero-extend to this width.
  localparam int ARB_MAX_N = 256;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // OR of the positions of all set bits; exact for a one-hot input.
  function automatic int unsigned oh_to_idx(input logic [ARB_MAX_N-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_prio_pick.sv
// rr_prio_pick: combinational rotating-priority picker.
// Returns the first set bit of req searching start, start+1, ..., N-1, 0, ...
// Ports:
//   req   [N-1:0]      request vector
//   start [IDX_W-1:0]  highest-priority index (must be < N)
//   gnt   [N-1:0]      one-hot grant, all-zero when req is zero
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   pick_rot;
  logic [2*N-1:0] pick_dbl;

  always_comb begin
    // Rotate right so requester 'start' lands on bit 0.
    req_dbl  = {req, req} >> start;
    req_rot  = req_dbl[N-1:0];
    // Lowest set bit wins after rotation.
    pick_rot = req_rot & (~req_rot + N'(1));
    // Rotate back left by the same amount.
    pick_dbl = {pick_rot, pick_rot} << start;
    gnt      = pick_dbl[2*N-1:N];
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with ack-qualified pointer advance and
// an optional grant lock for multi-cycle transactions.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   req_i  [N]  request vector, bit i = requester i
//   ack_i       downstream accepts the current grant this cycle
//   lock_i      with ack_i, the accepted grant stays with its owner
//   gnt_o  [N]  one-hot or zero grant, combinational from req_i and state
//   busy_o      high while LOCKED (this is the FSM state, exported for debug)
// Optional (macro RR_LOCK_ARB_GNT_IDX_EN):
//   gnt_idx_o [IDX_W]  binary index of the granted bit
//   gnt_vld_o          |gnt_o
// Handshake: a grant is consumed only in a cycle where gnt_o != 0 and ack_i=1;
// without ack the pointer holds and the grant may follow req_i freely.
// N up to ARB_MAX_N is supported by the index helper.
module rr_lock_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_i,
  input  logic             ack_i,
  input  logic             lock_i,
  output logic [N-1:0]     gnt_o,
  output logic             busy_o
`ifdef RR_LOCK_ARB_GNT_IDX_EN
  ,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
`endif
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N-1:0]     pick;
  logic [N-1:0]     owner_oh;
  logic             owner_req;
  logic [IDX_W-1:0] pick_idx;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    if (x == IDX_W'(N - 1)) return '0;
    return x + IDX_W'(1);
  endfunction

  rr_prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_i),
    .start (ptr_q),
    .gnt   (pick)
  );

  always_comb begin
    owner_oh  = N'(1) << owner_q;
    owner_req = |(req_i & owner_oh);
    pick_idx  = IDX_W'(oh_to_idx(ARB_MAX_N'(pick)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (ack_i && (|pick)) begin
          if (lock_i) begin
            owner_d = pick_idx;
            state_d = LOCKED;
          end else begin
            ptr_d = wrap_inc(pick_idx);
          end
        end
      end
      LOCKED: begin
        // Leave when the owner withdraws or acks its final (unlocked) beat.
        if (!owner_req || (ack_i && !lock_i)) begin
          ptr_d   = wrap_inc(owner_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o = '0;
    if (!reset) begin
      if (state_q == IDLE) gnt_o = pick;
      else if (owner_req)  gnt_o = owner_oh;
    end
  end

  assign busy_o = (state_q == LOCKED);

`ifdef RR_LOCK_ARB_GNT_IDX_EN
  // gnt_o is already zero in reset, so both follow it without extra gating.
  assign gnt_vld_o = |gnt_o;
  assign gnt_idx_o = IDX_W'(oh_to_idx(ARB_MAX_N'(gnt_o)));
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed bench for rr_lock_arbiter at N=4, N=5 and N=1.
// A search-based reference model (pointer, owner, locked flag per instance) is
// compared against every DUT each cycle outside reset; directed steps also
// check hand-computed grants. Optional ports checked under RR_LOCK_ARB_GNT_IDX_EN.
module tb_rr_lock_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic cmp_en = 1'b0;

  logic [3:0] req4 = '0;  logic ack4 = 1'b0, lock4 = 1'b0;
  logic [4:0] req5 = '0;  logic ack5 = 1'b0, lock5 = 1'b0;
  logic [0:0] req1 = '0;  logic ack1 = 1'b0, lock1 = 1'b0;
  logic [3:0] gnt4; logic busy4;
  logic [4:0] gnt5; logic busy5;
  logic [0:0] gnt1; logic busy1;
`ifdef RR_LOCK_ARB_GNT_IDX_EN
  logic [1:0] gidx4; logic gvld4;
  logic [2:0] gidx5; logic gvld5;
  logic [0:0] gidx1; logic gvld1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  rr_lock_arbiter #(.N(4)) u4 (
    .clk(clk), .reset(reset), .req_i(req4), .ack_i(ack4), .lock_i(lock4),
    .gnt_o(gnt4), .busy_o(busy4)
`ifdef RR_LOCK_ARB_GNT_IDX_EN
    , .gnt_idx_o(gidx4), .gnt_vld_o(gvld4)
`endif
  );
  rr_lock_arbiter #(.N(5)) u5 (
    .clk(clk), .reset(reset), .req_i(req5), .ack_i(ack5), .lock_i(lock5),
    .gnt_o(gnt5), .busy_o(busy5)
`ifdef RR_LOCK_ARB_GNT_IDX_EN
    , .gnt_idx_o(gidx5), .gnt_vld_o(gvld5)
`endif
  );
  rr_lock_arbiter #(.N(1)) u1 (
    .clk(clk), .reset(reset), .req_i(req1), .ack_i(ack1), .lock_i(lock1),
    .gnt_o(gnt1), .busy_o(busy1)
`ifdef RR_LOCK_ARB_GNT_IDX_EN
    , .gnt_idx_o(gidx1), .gnt_vld_o(gvld1)
`endif
  );

  // ---------------- accessors (k: 0=N4, 1=N5, 2=N1) ----------------
  function automatic int n_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 5 : 1;
  endfunction
  function automatic logic [31:0] get_req(input int k);
    return (k == 0) ? 32'(req4) : (k == 1) ? 32'(req5) : 32'(req1);
  endfunction
  function automatic logic get_ack(input int k);
    return (k == 0) ? ack4 : (k == 1) ? ack5 : ack1;
  endfunction
  function automatic logic get_lock(input int k);
    return (k == 0) ? lock4 : (k == 1) ? lock5 : lock1;
  endfunction
  function automatic logic [31:0] get_gnt(input int k);
    return (k == 0) ? 32'(gnt4) : (k == 1) ? 32'(gnt5) : 32'(gnt1);
  endfunction
  function automatic logic get_busy(input int k);
    return (k == 0) ? busy4 : (k == 1) ? busy5 : busy1;
  endfunction
`ifdef RR_LOCK_ARB_GNT_IDX_EN
  function automatic logic [31:0] get_gidx(input int k);
    return (k == 0) ? 32'(gidx4) : (k == 1) ? 32'(gidx5) : 32'(gidx1);
  endfunction
  function automatic logic get_gvld(input int k);
    return (k == 0) ? gvld4 : (k == 1) ? gvld5 : gvld1;
  endfunction
`endif

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ptr[3]    = '{0, 0, 0};
  int m_owner[3]  = '{0, 0, 0};
  bit m_locked[3] = '{1'b0, 1'b0, 1'b0};

  // Expected granted index, -1 for no grant.
  function automatic int model_pick(input int k, input logic [31:0] r);
    int n;
    n = n_of(k);
    if (m_locked[k]) return r[m_owner[k]] ? m_owner[k] : -1;
    for (int j = 0; j < n; j++) begin
      if (r[(m_ptr[k] + j) % n]) return (m_ptr[k] + j) % n;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g, n;
    logic [31:0] r;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_ptr[k]    <= 0;
        m_owner[k]  <= 0;
        m_locked[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        r = get_req(k);
        n = n_of(k);
        g = model_pick(k, r);
        if (!m_locked[k]) begin
          if (get_ack(k) && g >= 0) begin
            if (get_lock(k)) begin
              m_owner[k]  <= g;
              m_locked[k] <= 1'b1;
            end else begin
              m_ptr[k] <= (g + 1) % n;
            end
          end
        end else if (!r[m_owner[k]] || (get_ack(k) && !get_lock(k))) begin
          m_ptr[k]    <= (m_owner[k] + 1) % n;
          m_locked[k] <= 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int g;
    logic [31:0] ev;
    if (!reset && cmp_en) begin
      for (int k = 0; k < 3; k++) begin
        g  = model_pick(k, get_req(k));
        ev = (g >= 0) ? (32'd1 << g) : 32'd0;
        chk($sformatf("model_gnt_n%0d", n_of(k)), get_gnt(k), ev);
        chk($sformatf("model_busy_n%0d", n_of(k)), 32'(get_busy(k)), 32'(m_locked[k]));
`ifdef RR_LOCK_ARB_GNT_IDX_EN
        chk($sformatf("model_gidx_n%0d", n_of(k)), get_gidx(k), (g >= 0) ? 32'(g) : 32'd0);
        chk($sformatf("model_gvld_n%0d", n_of(k)), 32'(get_gvld(k)), 32'(g >= 0));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic apply(input int k, input logic [31:0] r, input logic a, input logic l);
    @(posedge clk);
    #1;
    case (k)
      0: begin req4 = r[3:0]; ack4 = a; lock4 = l; end
      1: begin req5 = r[4:0]; ack5 = a; lock5 = l; end
      default: begin req1 = r[0:0]; ack1 = a; lock1 = l; end
    endcase
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    #1 reset = 1'b1;
    req4 = 4'b1111; req5 = 5'b11111; req1 = 1'b1;
    @(negedge clk);
    chk("rst_gnt4", 32'(gnt4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_gnt5", 32'(gnt5), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    req4 = '0; req5 = '0; req1 = '0;
    cmp_en = 1'b1;

    // Alternating pair, every grant acked.
    apply(0, 32'b1010, 1, 0); chk("a0", 32'(gnt4), 32'b0010);
    apply(0, 32'b1010, 1, 0); chk("a1", 32'(gnt4), 32'b1000);
    apply(0, 32'b1010, 1, 0); chk("a2", 32'(gnt4), 32'b0010);
    apply(0, 32'b1010, 1, 0); chk("a3", 32'(gnt4), 32'b1000);

    // No ack: pointer holds. Then full rotation and wrap.
    for (int i = 0; i < 3; i++) begin
      apply(0, 32'b1111, 0, 0); chk("b_hold", 32'(gnt4), 32'b0001);
    end
    apply(0, 32'b1111, 1, 0); chk("b0", 32'(gnt4), 32'b0001);
    apply(0, 32'b1111, 1, 0); chk("b1", 32'(gnt4), 32'b0010);
    apply(0, 32'b1111, 1, 0); chk("b2", 32'(gnt4), 32'b0100);
    apply(0, 32'b1111, 1, 0); chk("b3", 32'(gnt4), 32'b1000);
    apply(0, 32'b1111, 0, 0); chk("b_wrap", 32'(gnt4), 32'b0001);

    // Lock on requester 1, final beat releases to 2.
    apply(0, 32'b1111, 1, 0); chk("c_ptr1", 32'(gnt4), 32'b0001);
    apply(0, 32'b1111, 1, 1); chk("c_lock", 32'(gnt4), 32'b0010);
    apply(0, 32'b1111, 0, 0); chk("c_held_g", 32'(gnt4), 32'b0010);
    chk("c_held_b", 32'(busy4), 32'd1);
    apply(0, 32'b1111, 1, 0); chk("c_last_g", 32'(gnt4), 32'b0010);
    chk("c_last_b", 32'(busy4), 32'd1);
    apply(0, 32'b1111, 0, 0); chk("c_after_g", 32'(gnt4), 32'b0100);
    chk("c_after_b", 32'(busy4), 32'd0);

    // Lock on 3, owner withdraws: exit and wrap to 0.
    apply(0, 32'b1111, 1, 0); chk("d_ptr3", 32'(gnt4), 32'b0100);
    apply(0, 32'b1111, 1, 1); chk("d_lock", 32'(gnt4), 32'b1000);
    apply(0, 32'b0001, 0, 0); chk("d_drop_g", 32'(gnt4), 32'b0000);
    chk("d_drop_b", 32'(busy4), 32'd1);
    apply(0, 32'b0001, 0, 0); chk("d_idle_g", 32'(gnt4), 32'b0001);
    chk("d_idle_b", 32'(busy4), 32'd0);

    // Lock on 2, then asynchronous reset mid-lock.
    apply(0, 32'b0100, 1, 1); chk("e_lock", 32'(gnt4), 32'b0100);
    apply(0, 32'b0100, 0, 0); chk("e_busy", 32'(busy4), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("e_rst_g", 32'(gnt4), 32'd0);
    chk("e_rst_b", 32'(busy4), 32'd0);
`ifdef RR_LOCK_ARB_GNT_IDX_EN
    chk("e_rst_vld", 32'(gvld4), 32'd0);
    chk("e_rst_idx", 32'(gidx4), 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    apply(0, 32'b1100, 0, 0); chk("e_after", 32'(gnt4), 32'b0100);
    chk("e_after_b", 32'(busy4), 32'd0);
    apply(0, 32'b0000, 0, 0);

    // N=5: alternation, full rotation with wrap, lock withdraw.
    apply(1, 32'b10001, 1, 0); chk("f0", 32'(gnt5), 32'b00001);
    apply(1, 32'b10001, 1, 0); chk("f1", 32'(gnt5), 32'b10000);
    apply(1, 32'b10001, 1, 0); chk("f2", 32'(gnt5), 32'b00001);
    apply(1, 32'b10001, 1, 0); chk("f3", 32'(gnt5), 32'b10000);
    for (int i = 0; i < 5; i++) begin
      apply(1, 32'b11111, 1, 0); chk("f_rot", 32'(gnt5), 32'd1 << i);
    end
    apply(1, 32'b11111, 0, 0); chk("f_wrap", 32'(gnt5), 32'b00001);
    apply(1, 32'b11111, 1, 1); chk("f_lock", 32'(gnt5), 32'b00001);
    apply(1, 32'b11110, 0, 0); chk("f_drop", 32'(gnt5), 32'b00000);
    apply(1, 32'b11110, 0, 0); chk("f_next", 32'(gnt5), 32'b00010);
    apply(1, 32'b00000, 0, 0);

    // N=1: grant follows request, lock still tracked.
    apply(2, 32'd1, 0, 0); chk("g0", 32'(gnt1), 32'd1);
    apply(2, 32'd0, 1, 0); chk("g1", 32'(gnt1), 32'd0);
    apply(2, 32'd1, 1, 1); chk("g2", 32'(gnt1), 32'd1);
    apply(2, 32'd1, 0, 0); chk("g3_g", 32'(gnt1), 32'd1);
    chk("g3_b", 32'(busy1), 32'd1);
    apply(2, 32'd0, 0, 0); chk("g4_g", 32'(gnt1), 32'd0);
    chk("g4_b", 32'(busy1), 32'd1);
    apply(2, 32'd1, 0, 0); chk("g5_g", 32'(gnt1), 32'd1);
    chk("g5_b", 32'(busy1), 32'd0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
